// File: rtl/rx_audio_pkg.sv
// Shared types for the RX audio sample-memory reader: FSM states, word width
// and the {last, data} word carried through the skid FIFO.
// Latency: n/a (types only).  Backpressure: n/a.
package rx_audio_pkg;

  localparam int RX_WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CTR,
    S_SAMP,
    S_DRAIN
  } rd_state_t;

  typedef struct packed {
    logic                 last;
    logic [RX_WORD_W-1:0] data;
  } rx_word_t;

endpackage

// File: rtl/rx_rd_skid.sv
// 2-entry FIFO of rx_word_t holding captured memory reads until downstream accepts.
// Latency: 1 cycle push-to-out_vld.
// Backpressure: out_rdy low holds out_dat; the upstream credit scheme guarantees no push when full.
// Ports: clk, rst (sync, active-high); push_vld/push_dat in; out_vld/out_rdy/out_dat stream; count = occupancy.
module rx_rd_skid
  import rx_audio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  rx_word_t   push_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output rx_word_t   out_dat,
  output logic [1:0] count
);

  rx_word_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;
  logic     pop;

  assign out_vld = (count != 2'd0);
  assign pop     = out_vld && out_rdy;
  // Zero the output when empty so the stream reads 0 after reset.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_vld) - 2'(pop);
    end
  end

endmodule

// File: rtl/rx_audio_rd_seq.sv
// Reads one RX sample-memory block per service request: ack, buffer counter, then nrx_samps*WORDS_PER_SAMP words.
// Latency: RD_LAT(=1)+1 cycles from a get_* strobe to the word appearing on o_data; 1 word/cycle sustained.
// Backpressure: o_ready low withholds read strobes via a 2-slot credit so no read data is ever dropped.
// Ports: cpu_clk, reset_C (sync, active-high), enable, nrx_samps; memory side rx_rd_C, rx_dout_C,
//        get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C; stream o_data/o_valid/o_last/o_ready; status busy, overrun.
module rx_audio_rd_seq
  import rx_audio_pkg::*;
#(
  parameter int WORDS_PER_SAMP = 2,
  parameter int NSAMP_W        = 16,
  parameter int RD_LAT         = 1
) (
  input  logic                 cpu_clk,
  input  logic                 reset_C,
  input  logic                 enable,
  input  logic [NSAMP_W-1:0]   nrx_samps,
  input  logic                 rx_rd_C,
  input  logic [RX_WORD_W-1:0] rx_dout_C,
  output logic                 get_rx_srq_C,
  output logic                 get_buf_ctr_C,
  output logic                 get_rx_samp_C,
  output logic [RX_WORD_W-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 o_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int WCNT_W = NSAMP_W + 3;

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic [NSAMP_W-1:0] nsamp_q;
  logic [WCNT_W-1:0]  wcnt;
  logic               pending;
  logic               pend_last;
  logic [1:0]         fifo_count;
  logic               fifo_pop;
  logic [2:0]         occ;
  logic               credit_ok;
  logic               rd_strobe;
  logic               strobe_last;
  rx_word_t           push_dat;
  rx_word_t           out_dat;

  // Occupancy net of this cycle's pop plus the read still in flight; a new
  // strobe lands next cycle, so below 2 guarantees it a slot.
  assign fifo_pop  = o_valid && o_ready;
  assign occ       = 3'(fifo_count) + 3'(pending) - 3'(fifo_pop);
  assign credit_ok = (occ < 3'd2);
  assign rd_strobe = get_buf_ctr_C || get_rx_samp_C;

  // State register
  always_ff @(posedge cpu_clk) begin
    if (reset_C) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && rx_rd_C) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_CTR;
      S_CTR:   if (credit_ok) state_nxt = (nsamp_q == '0) ? S_DRAIN : S_SAMP;
      S_SAMP:  if (credit_ok && (wcnt == WCNT_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if ((fifo_count == 2'd0) && !pending) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    get_rx_srq_C  = 1'b0;
    get_buf_ctr_C = 1'b0;
    get_rx_samp_C = 1'b0;
    strobe_last   = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_ACK: get_rx_srq_C = 1'b1;
      S_CTR: begin
        get_buf_ctr_C = credit_ok;
        strobe_last   = (nsamp_q == '0);
      end
      S_SAMP: begin
        get_rx_samp_C = credit_ok;
        strobe_last   = (wcnt == WCNT_W'(1));
      end
      default: ;
    endcase
  end

  // Block counters, read-pending pipe and sticky overrun
  always_ff @(posedge cpu_clk) begin
    if (reset_C) begin
      nsamp_q   <= '0;
      wcnt      <= '0;
      pending   <= 1'b0;
      pend_last <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == S_ACK) begin
        nsamp_q <= nrx_samps;
        wcnt    <= WCNT_W'(nrx_samps) * WCNT_W'(WORDS_PER_SAMP);
      end else if (get_rx_samp_C) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
      pending   <= rd_strobe;
      pend_last <= rd_strobe && strobe_last;
      // A request already waiting as the block finishes means the memory
      // filled the next buffer before we got back to it.
      if ((state == S_DRAIN) && (state_nxt == S_IDLE) && rx_rd_C) begin
        overrun <= 1'b1;
      end
    end
  end

  assign push_dat.last = pend_last;
  assign push_dat.data = rx_dout_C;

  rx_rd_skid u_skid (
    .clk      (cpu_clk),
    .rst      (reset_C),
    .push_vld (pending),
    .push_dat (push_dat),
    .out_vld  (o_valid),
    .out_rdy  (o_ready),
    .out_dat  (out_dat),
    .count    (fifo_count)
  );

  assign o_data = out_dat.data;
  assign o_last = out_dat.last;

  a_rd_lat: assert property (@(posedge cpu_clk) RD_LAT == 1);
  a_wps:    assert property (@(posedge cpu_clk) (WORDS_PER_SAMP >= 1) && (WORDS_PER_SAMP <= 7));
  a_excl:   assert property (@(posedge cpu_clk) disable iff (reset_C)
                             $onehot0({get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C}));

endmodule

// File: tb/tb_rx_audio_rd_seq.sv
module tb_rx_audio_rd_seq;

  localparam int WPS = 2;

  logic        clk = 1'b0;
  logic        reset_C = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] nrx_samps = 16'd0;
  logic        rx_rd_C = 1'b0;
  logic [15:0] rx_dout_C = 16'h0;
  logic        get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C;
  logic [15:0] o_data;
  logic        o_valid, o_last;
  logic        o_ready = 1'b1;
  logic        busy, overrun;

  int total = 0;
  int bad = 0;
  int srq_cnt = 0, ctr_cnt = 0, samp_cnt = 0, words_seen = 0;
  int blk_id = 0;
  int ready_mode = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  rx_audio_rd_seq #(.WORDS_PER_SAMP(WPS), .NSAMP_W(16), .RD_LAT(1)) u_dut (
    .cpu_clk      (clk),
    .reset_C      (reset_C),
    .enable       (enable),
    .nrx_samps    (nrx_samps),
    .rx_rd_C      (rx_rd_C),
    .rx_dout_C    (rx_dout_C),
    .get_rx_srq_C (get_rx_srq_C),
    .get_buf_ctr_C(get_buf_ctr_C),
    .get_rx_samp_C(get_rx_samp_C),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_ready      (o_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Expected words of one block: header then n*WPS sample words, last on the final one.
  task automatic push_block(input int n, input int blk);
    logic [16:0] w;
    w = {1'(n == 0), 16'hB000 + 16'(blk)};
    exp_q.push_back(w);
    for (int i = 0; i < n * WPS; i++) begin
      w = {1'(i == n * WPS - 1), 16'(i)};
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_counts();
    srq_cnt = 0; ctr_cnt = 0; samp_cnt = 0; words_seen = 0;
  endtask

  // Memory responder, o_ready driver and output scoreboard.
  task automatic env();
    logic        cap_ctr, cap_samp, prev_stall, toggle;
    logic [15:0] samp_val;
    logic [16:0] prev_word, got, exp_w;
    prev_stall = 1'b0; toggle = 1'b0; samp_val = 16'h0; prev_word = '0;
    forever begin
      @(negedge clk);
      cap_ctr  = get_buf_ctr_C;
      cap_samp = get_rx_samp_C;
      got      = {o_last, o_data};
      if (!reset_C) begin
        if (get_rx_srq_C) srq_cnt++;
        if (cap_ctr) ctr_cnt++;
        if (cap_samp) samp_cnt++;
        total++;
        if (int'(get_rx_srq_C) + int'(get_buf_ctr_C) + int'(get_rx_samp_C) > 1) begin
          bad++;
          $display("FAIL strobe_excl: got %b%b%b required at most one high", get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C);
        end
        total++;
        if (u_dut.fifo_count > 2'd2) begin
          bad++;
          $display("FAIL fifo_count: got %0d required <= 2", u_dut.fifo_count);
        end
        if (prev_stall) begin
          total++;
          if (!o_valid || got !== prev_word) begin
            bad++;
            $display("FAIL stall_hold: got v=%b w=%h required v=1 w=%h", o_valid, got, prev_word);
          end
        end
        if (o_valid && o_ready) begin
          total++;
          words_seen++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got %h required no word", got);
          end else begin
            exp_w = exp_q.pop_front();
            if (got !== exp_w) begin
              bad++;
              $display("FAIL stream_word: got last=%b data=%h required last=%b data=%h", got[16], got[15:0], exp_w[16], exp_w[15:0]);
            end
          end
        end
        prev_stall = o_valid && !o_ready;
        prev_word  = got;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      if (cap_ctr) begin
        rx_dout_C = 16'hB000 + 16'(blk_id);
        blk_id++;
        samp_val = 16'h0;
      end else if (cap_samp) begin
        rx_dout_C = samp_val;
        samp_val++;
      end else begin
        rx_dout_C = 16'hDEAD;
      end
      if (ready_mode == 0) begin
        o_ready = 1'b1;
      end else begin
        toggle  = ~toggle;
        o_ready = toggle && ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic request(output bit ok);
    ok = 1'b0;
    rx_rd_C = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (get_rx_srq_C) ok = 1'b1;
    end
    @(posedge clk);
    #1 rx_rd_C = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_C = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (get_rx_srq_C || get_buf_ctr_C || get_rx_samp_C) begin bad++; $display("FAIL rst_strobes: got %b%b%b required 000", get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C); end
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin bad++; $display("FAIL rst_valid_last: got %b%b required 00", o_valid, o_last); end
    total++; if (o_data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h required 0000", o_data); end
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_status: got busy=%b ovr=%b required 0 0", busy, overrun); end
    @(posedge clk);
    #1 reset_C = 1'b0;
  endtask

  task automatic test_basic_block();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 0; nrx_samps = 16'd7;
    push_block(7, 0);
    request(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_srq: got no ack required ack"); end
    wait_idle(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_idle: got timeout busy=%b left=%0d required idle", busy, exp_q.size()); end
    total++; if (srq_cnt != 1 || ctr_cnt != 1 || samp_cnt != 14) begin bad++; $display("FAIL basic_strobes: got %0d/%0d/%0d required 1/1/14", srq_cnt, ctr_cnt, samp_cnt); end
    total++; if (words_seen != 15) begin bad++; $display("FAIL basic_words: got %0d required 15", words_seen); end
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL basic_status: got busy=%b ovr=%b required 0 0", busy, overrun); end
  endtask

  task automatic test_zero_samples();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 0; nrx_samps = 16'd0;
    push_block(0, 0);
    request(ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_srq: got no ack required ack"); end
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_idle: got timeout required idle"); end
    total++; if (samp_cnt != 0 || ctr_cnt != 1) begin bad++; $display("FAIL zero_strobes: got ctr=%0d samp=%0d required 1 0", ctr_cnt, samp_cnt); end
    total++; if (words_seen != 1) begin bad++; $display("FAIL zero_words: got %0d required 1", words_seen); end
  endtask

  task automatic test_stalls();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 1; nrx_samps = 16'd679;
    push_block(679, 0);
    request(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_srq: got no ack required ack"); end
    wait_idle(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_idle: got timeout left=%0d required idle", exp_q.size()); end
    total++; if (words_seen != 1359) begin bad++; $display("FAIL stall_words: got %0d required 1359", words_seen); end
    total++; if (samp_cnt != 1358) begin bad++; $display("FAIL stall_samp: got %0d required 1358", samp_cnt); end
    ready_mode = 0;
    @(posedge clk);
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 0; nrx_samps = 16'd7;
    push_block(7, 0);
    request(ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_srq: got no ack required ack"); end
    for (int i = 0; i < 200 && words_seen < 5; i++) @(negedge clk);
    total++; if (words_seen < 5) begin bad++; $display("FAIL mrst_reach: got %0d words required 5", words_seen); end
    @(posedge clk);
    #1 reset_C = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 16'h0) begin bad++; $display("FAIL mrst_stream: got v=%b l=%b d=%h required 0 0 0000", o_valid, o_last, o_data); end
    total++; if (get_rx_srq_C || get_buf_ctr_C || get_rx_samp_C || busy) begin bad++; $display("FAIL mrst_ctrl: got strobes=%b%b%b busy=%b required 0", get_rx_srq_C, get_buf_ctr_C, get_rx_samp_C, busy); end
    total++; if (u_dut.fifo_count !== 2'd0) begin bad++; $display("FAIL mrst_fifo: got %0d required 0", u_dut.fifo_count); end
    @(posedge clk);
    #1 reset_C = 1'b0;
    clear_counts(); blk_id = 0; nrx_samps = 16'd2;
    push_block(2, 0);
    request(ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_srq2: got no ack required ack"); end
    wait_idle(200, ok);
    total++; if (!ok || words_seen != 5) begin bad++; $display("FAIL mrst_block2: got ok=%b words=%0d required 1 5", ok, words_seen); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 0; nrx_samps = 16'd3;
    for (int b = 0; b < 3; b++) push_block(3, b);
    rx_rd_C = 1'b1;
    for (int i = 0; i < 100 && srq_cnt < 1; i++) @(negedge clk);
    total++; if (srq_cnt < 1 || overrun !== 1'b0) begin bad++; $display("FAIL b2b_first: got srq=%0d ovr=%b required 1 0", srq_cnt, overrun); end
    for (int i = 0; i < 300 && srq_cnt < 3; i++) @(negedge clk);
    @(posedge clk);
    #1 rx_rd_C = 1'b0;
    wait_idle(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle: got timeout required idle"); end
    total++; if (srq_cnt != 3 || ctr_cnt != 3 || samp_cnt != 18) begin bad++; $display("FAIL b2b_strobes: got %0d/%0d/%0d required 3/3/18", srq_cnt, ctr_cnt, samp_cnt); end
    total++; if (words_seen != 21) begin bad++; $display("FAIL b2b_words: got %0d required 21", words_seen); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun: got %b required 1", overrun); end
  endtask

  task automatic test_enable();
    bit ok;
    clear_counts(); blk_id = 0; ready_mode = 0; nrx_samps = 16'd1;
    @(posedge clk);
    #1 enable = 1'b0; rx_rd_C = 1'b1;
    repeat (50) @(negedge clk);
    total++; if (srq_cnt + ctr_cnt + samp_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL en_off: got strobes=%0d busy=%b required 0 0", srq_cnt + ctr_cnt + samp_cnt, busy); end
    push_block(1, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    total++; if (get_rx_srq_C !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL en_same: got srq=%b busy=%b required 0 0", get_rx_srq_C, busy); end
    @(negedge clk);
    total++; if (get_rx_srq_C !== 1'b1) begin bad++; $display("FAIL en_ack: got %b required 1", get_rx_srq_C); end
    @(posedge clk);
    #1 rx_rd_C = 1'b0;
    wait_idle(100, ok);
    total++; if (!ok || words_seen != 3) begin bad++; $display("FAIL en_block: got ok=%b words=%0d required 1 3", ok, words_seen); end
  endtask

  initial begin
    fork
      env();
    join_none
    test_reset();
    test_basic_block();
    test_zero_samples();
    test_stalls();
    test_mid_reset();
    test_back_to_back();
    test_enable();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
